mul32_seq: RTL and testbench
============================

# mul32_seq

Sequential unsigned 32×32 shift-and-add multiplier for the processor's arithmetic unit. It consumes the 32-bit adder result once per cycle and accumulates a 64-bit product over 32 iterations. A start/busy/done handshake lets the datapath or control stall while a multiply is in flight. The block is the iterative stage directly downstream of the 32-bit adder.

## Interface
- `W`, default 32: operand width. The product is 2·W bits. The iteration counter is clog2(W) bits wide.
- `clk`  input  1  clock. All state changes on the rising edge.
- `rst_n`  input  1  reset. Synchronous and active-low.
- `start`  input  1  request a multiply. Sampled only in IDLE or DONE.
- `a`  input  W  multiplicand. Captured on the accepted start edge.
- `b`  input  W  multiplier. Captured on the accepted start edge.
- `busy`  output  1  high while iterating (state RUN).
- `done`  output  1  one-cycle pulse when the product is valid.
- `product`  output  2W  registered result. Holds its value until the next completion.

## Operation
- Internal registers:
  - `mcand[W-1:0]`
  - `acc[W-1:0]` (upper half)
  - `mplr[W-1:0]` (lower half / remaining multiplier bits)
  - `cnt`
  - `state`
- States: IDLE, RUN, DONE.
- **IDLE**
  - If `start`=1: mcand←a, mplr←b, acc←0, cnt←0, go to RUN.
  - Otherwise stay in IDLE.
- **RUN** (one iteration per cycle)
  - sum[W:0] = {1'b0,acc} + (mplr[0] ? {1'b0,mcand} : 0). This is a 33-bit add; the carry is kept.
  - {acc,mplr} ← {sum[W:0], mplr[W-1:1]}, i.e. a right shift with the carry entering acc[W-1].
  - cnt←cnt+1.
  - When cnt==W-1 in this cycle: product ← final {acc,mplr} value (the post-shift value), go to DONE.
- **DONE**
  - done=1 for exactly this one cycle.
  - If `start`=1: accept a new operation exactly as in IDLE and go to RUN.
  - Otherwise go to IDLE.
- `start` is ignored in RUN. It is not queued, and operands are not re-captured.
- Changes on `a`/`b` after the accepting edge have no effect.
- `product` is updated only on completion. During a new RUN it still shows the previous result.
- Arithmetic is unsigned. The 2W-bit result is exact; there is no overflow and no truncation.
- Reset (`rst_n`=0 at a rising edge) has priority over everything else:
  - state→IDLE, busy=0, done=0, product=0.
  - acc, mplr, mcand and cnt→0.
  - A reset during RUN aborts the operation. No done pulse follows.

## Timing
- `busy` = (state==RUN). `done` = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- Latency: if start is accepted at edge N, then:
  - busy is high from edge N to edge N+W.
  - done is high from edge N+W to edge N+W+1.
  - product is valid from edge N+W onward.
- For W=32: done is asserted 32 cycles after the accepting edge.
- Throughput: back-to-back operations are possible when start is held in the DONE cycle. Each operation takes W+1 cycles, i.e. 33 for W=32.
- Cycles after reset deassertion: the first edge with rst_n=1 may accept start.
- Reset values of outputs: busy=0, done=0, product=0.

## Test plan
- a=3, b=5, 1-cycle start pulse from IDLE:
  - busy high for 32 cycles.
  - done pulses exactly once, 32 edges after start.
  - product=64'h0000_0000_0000_000F.
- a=32'hFFFF_FFFF, b=32'hFFFF_FFFF:
  - product=64'hFFFF_FFFE_0000_0001. This checks carry retention in the 33-bit add.
- a=32'h1234_5678, b=0, then a=0, b=32'hDEAD_BEEF: product=0 both times, each with a single done pulse.
- Start a=7, b=6. Then pulse start with a=9, b=9 at cycle 10 of RUN, and change a/b every cycle during RUN:
  - product=42.
  - Only one done pulse.
  - The second start is ignored.
- Start a=2, b=3 and hold start high through the DONE cycle with a=4, b=5:
  - done pulses with product=6.
  - busy is re-asserted the next cycle.
  - product stays 6 during the second RUN, then becomes 20 with a second done pulse.
- Start a=100, b=100 and drive rst_n=0 for one edge at cycle 15 of RUN:
  - busy=0, done=0, product=0 from the next edge.
  - No done pulse follows.
  - A subsequent start with a=10, b=10 yields product=100.

Source files
------------

// File: rtl/mul32_seq.sv
// rtl/mul32_seq.sv - sequential unsigned WxW shift-and-add multiplier
module mul32_seq #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_mcand;
  logic [W-1:0]   r_acc;
  logic [W-1:0]   r_mplr;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_done;
  logic [2*W-1:0] r_product;

  // The carry out of the add lands in acc[W-1] after the shift, so nothing is lost.
  logic [W:0]     w_sum;
  logic [2*W-1:0] w_next;

  assign w_sum  = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_mcand} : {(W+1){1'b0}});
  assign w_next = {w_sum, r_mplr[W-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mplr    <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_acc  <= w_next[2*W-1:W];
          r_mplr <= w_next[W-1:0];
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_product <= w_next;
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new operation; DONE otherwise falls back to IDLE.
          r_done <= 1'b0;
          if (start) begin
            r_mcand <= a;
            r_mplr  <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_mul32_seq.sv
// tb/tb_mul32_seq.sv - scoreboard bench for mul32_seq with random operands
module tb_mul32_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  mul32_seq #(.W(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xx;
    logic [63:0] yy;
    xx = {32'd0, x};
    yy = {32'd0, y};
    return xx * yy;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%h expected=no_pulse", product);
      end else begin
        check("product", product, exp_q.pop_front());
      end
    end
  end

  // Called #1 after an edge: drives start with operands, accepted at the next edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    a     = x;
    b     = y;
    exp_q.push_back(model(x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Runs from just after the accepting edge until done is seen; scrambles a/b every cycle.
  task automatic wait_done(input int poke, input logic hold_chk, input logic [63:0] hold_val,
                           input int hold_from);
    int lat;
    int busy_bad;
    int hold_bad;
    lat      = 0;
    busy_bad = 0;
    hold_bad = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) busy_bad++;
      if (hold_chk && product !== hold_val) hold_bad++;
      start = (lat == poke) || (lat >= hold_from);
      a     = (lat >= hold_from) ? 32'd4 : $urandom;
      b     = (lat >= hold_from) ? 32'd5 : $urandom;
      if (lat == hold_from) exp_q.push_back(model(32'd4, 32'd5));
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd32);
    check("busy_low_cycles", 64'(busy_bad), 64'd0);
    if (hold_chk) check("product_hold", 64'(hold_bad), 64'd0);
  endtask

  task automatic after_done_idle();
    start = 1'b0;
    @(posedge clk);
    #1;
    check("done_single", {63'd0, done}, 64'd0);
    check("busy_after", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0;
    a     = '0;
    b     = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_product", product, 64'd0);
    rst_n = 1'b1;

    // Directed cases from the first edge after reset release.
    issue(32'd3, 32'd5);
    wait_done(-1, 1'b1, 64'd0, 99);
    after_done_idle();
    check("product_held", product, 64'hF);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(-1, 1'b1, 64'hF, 99);
    after_done_idle();

    issue(32'h1234_5678, 32'd0);
    wait_done(-1, 1'b0, 64'd0, 99);
    after_done_idle();
    issue(32'd0, 32'hDEAD_BEEF);
    wait_done(-1, 1'b0, 64'd0, 99);
    after_done_idle();

    // Start pulse during RUN must be ignored.
    issue(32'd7, 32'd6);
    wait_done(10, 1'b1, 64'd0, 99);
    after_done_idle();
    check("product_42", product, 64'd42);

    // Back-to-back: start held from the last RUN cycle through DONE.
    issue(32'd2, 32'd3);
    wait_done(-1, 1'b0, 64'd0, 31);
    check("b2b_first", product, 64'd6);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", {63'd0, busy}, 64'd1);
    check("b2b_done_low", {63'd0, done}, 64'd0);
    wait_done(-1, 1'b1, 64'd6, 99);
    after_done_idle();
    check("b2b_second", product, 64'd20);

    // Reset mid-RUN aborts without a done pulse.
    issue(32'd100, 32'd100);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_product", product, 64'd0);
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    issue(32'd10, 32'd10);
    wait_done(-1, 1'b1, 64'd0, 99);
    after_done_idle();
    check("after_abort", product, 64'd100);

    // Random operands with random idle gaps.
    for (int i = 0; i < 25; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [63:0] prev;
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) ra = 32'hFFFF_FFFF;
      if (i % 7 == 0) rb = 32'h8000_0001;
      prev = product;
      issue(ra, rb);
      wait_done(-1, 1'b1, prev, 99);
      after_done_idle();
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
